// File: rtl/seg7_counter_mux.sv
// N-digit BCD up/down counter with programmable prescaler and a time-multiplexed 7-segment scan.
// tick is combinational off the prescaler; digits, wrap, segments and digit_sel are registered.
module seg7_counter_mux #(
    parameter int          NUM_DIGITS = 4,
    parameter logic [23:0] MAX_COUNT  = 24'd10_000_000,
    parameter logic [15:0] SCAN_DIV   = 16'd10_000,
    parameter bit          BLANK_LZ   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic [7:0]              cmp_in,
    input  logic                    run,
    input  logic                    up_dn,
    input  logic                    clear,
    output logic [6:0]              segments,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic [4*NUM_DIGITS-1:0] count_bcd,
    output logic                    tick,
    output logic                    wrap
);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [23:0]              r_presc;
    logic [4*NUM_DIGITS-1:0]  r_digits;
    logic                     r_wrap;
    logic [15:0]              r_scan_cnt;
    logic [IW-1:0]            r_idx;
    logic [NUM_DIGITS-1:0]    r_digit_sel;
    logic [6:0]               r_segments;

    logic [23:0]              w_cmp;
    logic                     w_tick;
    logic [4*NUM_DIGITS-1:0]  w_digits_nxt;
    logic                     w_ripple;
    logic [NUM_DIGITS-1:0]    w_lz;
    logic                     w_zacc;
    logic                     w_scan_end;
    logic [IW-1:0]            w_idx_nxt;
    logic [3:0]               w_sel_dig;
    logic                     w_sel_blank;
    logic [NUM_DIGITS-1:0]    w_sel_onehot;
    logic [6:0]               w_seg_nxt;

    function automatic logic [6:0] f_decode(input logic [3:0] d);
        case (d)
            4'd0:    f_decode = 7'b0111111;
            4'd1:    f_decode = 7'b0000110;
            4'd2:    f_decode = 7'b1011011;
            4'd3:    f_decode = 7'b1001111;
            4'd4:    f_decode = 7'b1100110;
            4'd5:    f_decode = 7'b1101101;
            4'd6:    f_decode = 7'b1111101;
            4'd7:    f_decode = 7'b0000111;
            4'd8:    f_decode = 7'b1111111;
            4'd9:    f_decode = 7'b1101111;
            default: f_decode = 7'b0000000;
        endcase
    endfunction

    // >= rather than == so a lowered compare value expires immediately instead of overrunning
    assign w_cmp  = (cmp_in == 8'd0) ? MAX_COUNT : {6'b0, cmp_in, 10'b0};
    assign w_tick = rst_n & ena & run & ~clear & (r_presc >= w_cmp);

    // Single-cycle ripple; w_ripple survives the loop only if every digit rolled over
    always_comb begin
        w_digits_nxt = r_digits;
        w_ripple     = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_ripple) begin
                if (up_dn) begin
                    if (r_digits[4*i +: 4] == 4'd9) begin
                        w_digits_nxt[4*i +: 4] = 4'd0;
                    end else begin
                        w_digits_nxt[4*i +: 4] = r_digits[4*i +: 4] + 4'd1;
                        w_ripple               = 1'b0;
                    end
                end else begin
                    if (r_digits[4*i +: 4] == 4'd0) begin
                        w_digits_nxt[4*i +: 4] = 4'd9;
                    end else begin
                        w_digits_nxt[4*i +: 4] = r_digits[4*i +: 4] - 4'd1;
                        w_ripple               = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc  <= '0;
            r_digits <= '0;
            r_wrap   <= 1'b0;
        end else if (ena) begin
            if (clear) begin
                r_presc  <= '0;
                r_digits <= '0;
                r_wrap   <= 1'b0;
            end else if (run) begin
                if (w_tick) begin
                    r_presc  <= '0;
                    r_digits <= w_digits_nxt;
                    r_wrap   <= w_ripple;
                end else begin
                    r_presc  <= r_presc + 24'd1;
                    r_wrap   <= 1'b0;
                end
            end else begin
                r_wrap <= 1'b0;
            end
        end
    end

    // w_lz[i]: digit i and everything above it are zero
    always_comb begin
        w_lz   = '0;
        w_zacc = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_zacc  = w_zacc & (r_digits[4*i +: 4] == 4'd0);
            w_lz[i] = w_zacc;
        end
    end

    assign w_scan_end = (r_scan_cnt == SCAN_DIV - 16'd1);
    assign w_idx_nxt  = (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;

    always_comb begin
        w_sel_dig    = 4'd0;
        w_sel_blank  = 1'b0;
        w_sel_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_idx_nxt == IW'(i)) begin
                w_sel_dig       = r_digits[4*i +: 4];
                w_sel_blank     = BLANK_LZ && (i != 0) && w_lz[i];
                w_sel_onehot[i] = 1'b1;
            end
        end
    end

    assign w_seg_nxt = w_sel_blank ? 7'd0 : f_decode(w_sel_dig);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt  <= '0;
            r_idx       <= '0;
            r_digit_sel <= '0;
            r_segments  <= '0;
        end else if (ena) begin
            if (w_scan_end) begin
                r_scan_cnt  <= '0;
                r_idx       <= w_idx_nxt;
                r_digit_sel <= w_sel_onehot;
                r_segments  <= w_seg_nxt;
            end else begin
                r_scan_cnt  <= r_scan_cnt + 16'd1;
            end
        end
    end

    assign segments  = r_segments;
    assign digit_sel = r_digit_sel;
    assign count_bcd = r_digits;
    assign tick      = w_tick;
    assign wrap      = r_wrap;
endmodule

// File: tb/tb_seg7_counter_mux.sv
// Directed + random bench for seg7_counter_mux against an integer model of a 0..99 counter and scan.
module tb_seg7_counter_mux;
    logic       clk = 1'b0;
    logic       rst_n, ena, run, up_dn, clear;
    logic [7:0] cmp_in;
    logic [6:0] segments;
    logic [1:0] digit_sel;
    logic [7:0] count_bcd;
    logic       tick, wrap;

    seg7_counter_mux #(
        .NUM_DIGITS(2), .MAX_COUNT(24'd4), .SCAN_DIV(16'd3), .BLANK_LZ(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .cmp_in(cmp_in), .run(run),
        .up_dn(up_dn), .clear(clear), .segments(segments), .digit_sel(digit_sel),
        .count_bcd(count_bcd), .tick(tick), .wrap(wrap)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [6:0] seg_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                                 7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

    // Model state: counter as a plain integer 0..99, scan as phase/index
    int         m_presc, m_cnt, m_sc, m_idx;
    logic [1:0] m_dsel;
    logic [6:0] m_seg;
    logic       m_wrap, m_tick_now;
    int         n_tick_obs, n_wrap_obs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp_v);
        end
    endtask

    function automatic int cmpv();
        return (cmp_in == 8'd0) ? 4 : int'(cmp_in) * 1024;
    endfunction

    function automatic int bcd(input int v);
        return (v / 10) * 16 + (v % 10);
    endfunction

    function automatic logic [6:0] exp_seg(input int idx, input int cnt);
        int d;
        d = (idx == 0) ? cnt % 10 : (cnt / 10) % 10;
        if (idx != 0 && cnt < 10) return 7'd0;
        return seg_tab[d];
    endfunction

    task automatic m_reset();
        m_presc = 0; m_cnt = 0; m_sc = 0; m_idx = 0;
        m_dsel = 2'b00; m_seg = 7'd0; m_wrap = 1'b0;
    endtask

    task automatic model_step();
        if (!rst_n) begin
            m_reset();
        end else if (ena) begin
            if (m_sc == 2) begin
                m_sc   = 0;
                m_idx  = (m_idx + 1) % 2;
                m_dsel = 2'(1 << m_idx);
                m_seg  = exp_seg(m_idx, m_cnt);
            end else begin
                m_sc++;
            end
            if (clear) begin
                m_presc = 0; m_cnt = 0; m_wrap = 1'b0;
            end else if (run) begin
                if (m_presc >= cmpv()) begin
                    m_wrap  = up_dn ? (m_cnt == 99) : (m_cnt == 0);
                    m_cnt   = up_dn ? (m_cnt + 1) % 100 : (m_cnt + 99) % 100;
                    m_presc = 0;
                end else begin
                    m_presc++;
                    m_wrap = 1'b0;
                end
            end else begin
                m_wrap = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        m_tick_now = rst_n && ena && run && !clear && (m_presc >= cmpv());
        chk("tick",      32'(tick),      32'(m_tick_now));
        chk("count_bcd", 32'(count_bcd), 32'(bcd(m_cnt)));
        chk("digit_sel", 32'(digit_sel), 32'(m_dsel));
        chk("segments",  32'(segments),  32'(m_seg));
        chk("wrap",      32'(wrap),      32'(m_wrap));
        chk("nib_lo_le9", 32'(count_bcd[3:0] <= 4'd9), 32'd1);
        chk("nib_hi_le9", 32'(count_bcd[7:4] <= 4'd9), 32'd1);
        if (tick === 1'b1) n_tick_obs++;
        if (wrap === 1'b1) n_wrap_obs++;
    endtask

    task automatic cyc();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic run_ticks(input int n);
        int got;
        got = 0;
        for (int k = 0; k < n * 1100 + 20 && got < n; k++) begin
            cyc();
            if (m_tick_now) got++;
        end
        chk("tick_budget", 32'(got), 32'(n));
    endtask

    task automatic scan_check(input logic [6:0] seg_d0, input logic [6:0] seg_d1);
        logic [1:0] prev, cur;
        int len;
        bit started;
        prev = digit_sel; len = 0; started = 1'b0;
        for (int k = 0; k < 14; k++) begin
            cyc();
            cur = digit_sel;
            if (cur == prev) begin
                len++;
            end else begin
                if (started) chk("scan_hold_len", 32'(len), 32'd3);
                started = 1'b1; len = 1; prev = cur;
            end
            if (cur == 2'b01) chk("scan_seg_d0", 32'(segments), 32'(seg_d0));
            if (cur == 2'b10) chk("scan_seg_d1", 32'(segments), 32'(seg_d1));
        end
    endtask

    initial begin
        int t0, w0, per;
        logic [1:0] s_dsel;
        logic [6:0] s_seg;
        int s_cnt;

        rst_n = 1'b0; ena = 1'b1; run = 1'b1; up_dn = 1'b1; clear = 1'b0; cmp_in = 8'd0;
        n_tick_obs = 0; n_wrap_obs = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count_bcd), 32'd0);
        chk("rst_dsel",  32'(digit_sel), 32'd0);
        chk("rst_seg",   32'(segments),  32'd0);
        chk("rst_tick",  32'(tick),      32'd0);
        chk("rst_wrap",  32'(wrap),      32'd0);
        rst_n = 1'b1;

        // First ticks: period of MAX_COUNT+1 = 5 cycles
        t0 = n_tick_obs;
        repeat (15) cyc();
        chk("three_ticks_cnt", 32'(count_bcd), 32'h03);
        chk("three_ticks_n",   32'(n_tick_obs - t0), 32'd3);

        // Asynchronous reset mid-period
        repeat (2) cyc();
        rst_n = 1'b0;
        #1;
        chk("async_rst_count", 32'(count_bcd), 32'd0);
        chk("async_rst_dsel",  32'(digit_sel), 32'd0);
        chk("async_rst_seg",   32'(segments),  32'd0);
        chk("async_rst_tick",  32'(tick),      32'd0);
        m_reset();
        cyc();
        rst_n = 1'b1;

        // Carry and up-wrap
        run_ticks(98);
        chk("preload_98", 32'(count_bcd), 32'h98);
        run_ticks(1);
        chk("up_99", 32'(count_bcd), 32'h99);
        w0 = n_wrap_obs;
        run_ticks(1);
        cyc(); cyc();
        chk("up_wrap_00",  32'(count_bcd), 32'h00);
        chk("up_wrap_one", 32'(n_wrap_obs - w0), 32'd1);

        // Down-wrap and borrow
        up_dn = 1'b0;
        w0 = n_wrap_obs;
        run_ticks(1);
        cyc(); cyc();
        chk("dn_wrap_99",  32'(count_bcd), 32'h99);
        chk("dn_wrap_one", 32'(n_wrap_obs - w0), 32'd1);
        run_ticks(89);
        chk("dn_10", 32'(count_bcd), 32'h10);
        run_ticks(1);
        chk("borrow_09", 32'(count_bcd), 32'h09);

        // Hold
        run = 1'b0;
        s_cnt = m_cnt; t0 = n_tick_obs;
        repeat (20) cyc();
        chk("hold_count", 32'(count_bcd), 32'(bcd(s_cnt)));
        chk("hold_tick",  32'(n_tick_obs - t0), 32'd0);
        run = 1'b1;
        repeat (7) cyc();

        // Clear on a tick cycle
        for (int k = 0; k < 10 && m_presc != 4; k++) cyc();
        chk("clear_align", 32'(m_presc), 32'd4);
        clear = 1'b1;
        t0 = n_tick_obs; w0 = n_wrap_obs;
        cyc();
        clear = 1'b0;
        chk("clear_count",   32'(count_bcd), 32'h00);
        chk("clear_no_tick", 32'(n_tick_obs - t0), 32'd0);
        cyc();
        chk("clear_no_wrap", 32'(n_wrap_obs - w0), 32'd0);

        // Programmed compare 1024 -> period 1025
        cmp_in = 8'd1;
        run_ticks(1);
        per = 0; t0 = n_tick_obs;
        for (int k = 0; k < 1100 && n_tick_obs == t0; k++) begin
            cyc();
            per++;
        end
        chk("period_1025", 32'(per), 32'd1025);

        // Lowering compare below presc expires at once
        cmp_in = 8'd2;
        repeat (1500) cyc();
        cmp_in = 8'd1;
        t0 = n_tick_obs;
        cyc();
        chk("lower_cmp_tick", 32'(n_tick_obs - t0), 32'd1);
        cmp_in = 8'd0;
        cyc();

        // Scan and leading-zero blanking at 07, then 40
        clear = 1'b1; cyc(); clear = 1'b0;
        up_dn = 1'b1;
        run_ticks(7);
        run = 1'b0;
        chk("scan_cnt_07", 32'(count_bcd), 32'h07);
        repeat (6) cyc();
        scan_check(7'b0000111, 7'b0000000);
        run = 1'b1;
        run_ticks(33);
        run = 1'b0;
        chk("scan_cnt_40", 32'(count_bcd), 32'h40);
        repeat (6) cyc();
        scan_check(7'b0111111, 7'b1100110);
        run = 1'b1;

        // ena = 0 freezes everything, then resumes from the held phase
        repeat (4) cyc();
        ena = 1'b0;
        s_dsel = m_dsel; s_seg = m_seg; s_cnt = m_cnt;
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk("ena0_dsel",  32'(digit_sel), 32'(s_dsel));
            chk("ena0_seg",   32'(segments),  32'(s_seg));
            chk("ena0_count", 32'(count_bcd), 32'(bcd(s_cnt)));
        end
        ena = 1'b1;
        repeat (10) cyc();

        // Randomized control mix
        for (int k = 0; k < 400; k++) begin
            ena   = ($urandom_range(0, 9) != 0);
            run   = ($urandom_range(0, 9) != 0);
            up_dn = 1'($urandom_range(0, 1));
            clear = ($urandom_range(0, 29) == 0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seg7_counter_mux.md
Name: seg7_counter_mux

Overview:
- Parametrised multi-digit successor to the single-digit seconds counter.
- A programmable prescaler generates ticks. Each tick steps an N-digit BCD counter up or down, with carry and borrow rippling between digits.
- The digits are time-multiplexed onto one shared 7-segment bus with a one-hot digit select.
- Sits between the top-level pin wrapper (switch inputs, segment and GPIO outputs) and the display.

Parameters:
- NUM_DIGITS, 4, number of BCD digits (1..8).
- MAX_COUNT, 24'd10_000_000, prescaler compare value used when cmp_in == 0.
- SCAN_DIV, 16'd10_000, clock cycles per digit in the display scan (>= 1).
- BLANK_LZ, 1, 1 = blank leading zero digits (digit 0 is never blanked).

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- ena, input, 1, design enable; 0 freezes all state except reset.
- cmp_in, input, 8, prescaler select; 0 uses MAX_COUNT, otherwise compare = {6'b0, cmp_in, 10'b0}.
- run, input, 1, 1 = prescaler and counter advance; 0 = hold.
- up_dn, input, 1, 1 = count up, 0 = count down.
- clear, input, 1, synchronous clear of prescaler and digits.
- segments, output, 7, gfedcba, active-high, registered.
- digit_sel, output, NUM_DIGITS, one-hot active-high digit enable, registered.
- count_bcd, output, 4*NUM_DIGITS, live BCD value; digit 0 in [3:0].
- tick, output, 1, one-cycle pulse when the prescaler expires.
- wrap, output, 1, one-cycle pulse when the whole counter wraps (all 9s -> 0 up, or 0 -> all 9s down).

Behaviour:
- Reset (async assert, sync release):
  - Prescaler, digits, scan counter and scan index are 0.
  - digit_sel = 0, segments = 0, tick = 0, wrap = 0.
- Prescaler:
  - When ena & run & !clear: if presc >= compare, presc <= 0 and tick pulses in the same cycle; else presc <= presc + 1.
  - Period is compare+1 cycles.
  - The >= comparison means lowering cmp_in below the current presc value produces a tick on the next cycle, with no 2^24 overrun.
  - run = 0 holds presc and the digits and forces tick = 0.
- Counter, on tick:
  - Up: digit 0 increments. A digit at 9 becomes 0 and carries to the next digit in the same cycle (full ripple, single cycle).
  - Down: digit 0 decrements. A digit at 0 becomes 9 and borrows from the next digit.
  - wrap is registered and pulses in the same cycle the digits update to the wrapped value:
    - Up: all digits 9 -> all digits 0.
    - Down: all digits 0 -> all digits 9.
  - Digits never hold values 10..15.
  - up_dn is sampled only on tick cycles, so changing it mid-period has no effect until the next tick.
- clear:
  - Highest priority below reset; takes effect only while ena = 1.
  - Next edge: presc = 0, digits = 0, tick = 0, wrap = 0.
  - clear together with a tick: clear wins and the tick is suppressed.
- Scan:
  - scan_cnt runs 0..SCAN_DIV-1 while ena = 1, independent of run and clear.
  - At the terminal count, idx <= (idx == NUM_DIGITS-1) ? 0 : idx + 1.
  - Also at the terminal count, digit_sel <= one-hot(idx_next) and segments <= decode(digit[idx_next]), so both outputs change in the same cycle.
  - The first non-zero digit_sel appears SCAN_DIV cycles after reset release and selects digit 1, or digit 0 if NUM_DIGITS == 1.
  - When a digit changes while it is displayed, segments update at the next scan step, not mid-step.
- Blanking: with BLANK_LZ = 1, a digit is blanked (segments = 0) if it and all higher digits are 0. digit_sel still asserts for a blanked digit.
- Decode (gfedcba):
  - 0 = 0111111, 1 = 0000110, 2 = 1011011, 3 = 1001111, 4 = 1100110.
  - 5 = 1101101, 6 = 1111101, 7 = 0000111, 8 = 1111111, 9 = 1101111.
- ena = 0 freezes every register, including scan state; outputs hold their last values.

Test Plan:
- Bench parameters: NUM_DIGITS = 2, MAX_COUNT = 4, SCAN_DIV = 3, BLANK_LZ = 1.
- Reset and first tick: release rst_n, run = 1, up_dn = 1, cmp_in = 0 -> tick pulses every 5 cycles; after 3 ticks count_bcd = 8'h03; rst_n low mid-period -> all outputs 0 immediately, without waiting for a clock edge.
- Carry and wrap: preload count_bcd = 8'h98 by ticking up, then tick once -> 8'h99, tick again -> 8'h00 with wrap high for exactly 1 cycle; no value above 9 appears in either nibble.
- Down and borrow: from 8'h10 with up_dn = 0, tick -> 8'h09; from 8'h00, tick -> 8'h99 with wrap pulsing.
- Control: run = 0 for 20 cycles -> count_bcd, presc and tick frozen; clear asserted on the tick cycle -> count_bcd = 8'h00 and no tick or wrap pulse; cmp_in set to 1 -> compare = 1024, period 1025 cycles; lowering cmp_in mid-period -> tick on the next cycle.
- Scan and blanking with count = 8'h07:
  - digit_sel alternates 01 and 10, each held exactly 3 cycles.
  - digit_sel = 01 -> segments = 0000111.
  - digit_sel = 10 -> segments = 0 (leading zero blanked).
  - At count = 8'h40, digit 0 shows 0111111 (not blanked).
- ena = 0 for 10 cycles -> digit_sel, segments and count_bcd are unchanged; on ena = 1, scan resumes from the held phase.
